// File: rtl/btn_conditioner.sv
// btn_conditioner: per-button 2-flop sync, debounce, press/release pulses; auto-repeat when BTN_AUTOREPEAT_EN is defined.
// Latency: DB_CYCLES+2 clk from a clean raw edge to btn_level/btn_press; no backpressure, outputs are free-running pulses.
module btn_conditioner #(
  parameter int N_BTN         = 3,
  parameter int DB_CYCLES     = 650000,
  parameter int REPEAT_DELAY  = 32500000,
  parameter int REPEAT_PERIOD = 6500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  localparam int              DB_W    = $clog2(DB_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  if (N_BTN < 1 || N_BTN > 16 || DB_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("btn_conditioner: parameter out of range");
  end

  logic [N_BTN-1:0] sync_q1;
  logic [N_BTN-1:0] sync_q2;
  logic [DB_W-1:0]  db_cnt [N_BTN];
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
    end
  end

  // The level flips on the cycle the counter would reach DB_CYCLES.
  always_comb begin
    rise = '0;
    fall = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (sync_q2[i] != btn_level[i] && db_cnt[i] == DB_LAST) begin
        rise[i] = ~btn_level[i];
        fall[i] = btn_level[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_level   <= '0;
      btn_release <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      btn_level   <= btn_level ^ (rise | fall);
      btn_release <= fall;
      for (int i = 0; i < N_BTN; i++) begin
        if (sync_q2[i] == btn_level[i] || rise[i] || fall[i]) begin
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RD_LOAD = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RP_LOAD = RPT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_DELAY,
    REPEATING
  } rpt_state_t;

  rpt_state_t       rpt_state [N_BTN];
  logic [RPT_W-1:0] rpt_cnt   [N_BTN];

  // Counter counts down to zero and is reloaded on every pulse, so it never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_press <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        rpt_state[i] <= IDLE;
        rpt_cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        btn_press[i] <= 1'b0;
        if (fall[i]) begin
          rpt_state[i] <= IDLE;
          rpt_cnt[i]   <= '0;
        end else begin
          case (rpt_state[i])
            IDLE: begin
              if (rise[i]) begin
                btn_press[i] <= 1'b1;
                rpt_state[i] <= WAIT_DELAY;
                rpt_cnt[i]   <= RD_LOAD;
              end
            end
            WAIT_DELAY, REPEATING: begin
              if (rpt_cnt[i] == '0) begin
                btn_press[i] <= 1'b1;
                rpt_state[i] <= REPEATING;
                rpt_cnt[i]   <= RP_LOAD;
              end else begin
                rpt_cnt[i] <= rpt_cnt[i] - RPT_W'(1);
              end
            end
            default: begin
              rpt_state[i] <= IDLE;
              rpt_cnt[i]   <= '0;
            end
          endcase
        end
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_press <= '0;
    end else begin
      btn_press <= rise;
    end
  end
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenarios with literal expectations plus random stimulus vs. a timing model.
module tb_btn_conditioner;
  localparam int N  = 3;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;

  int checks   = 0;
  int failures = 0;

  btn_conditioner #(
    .N_BTN(N), .DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Timing model: edge counting. A channel's level flips once its synchronised
  // sample has disagreed with the level for DB consecutive edges; repeat pulses
  // fall at press_time + RD + k*RP while the level stays high.
  int           cyc = 0;
  logic [N-1:0] m_s1 = '0, m_s2 = '0, m_lvl = '0, m_press = '0, m_rel = '0;
  int           anchor  [N];
  int           press_t [N];

  always @(posedge clk) begin : model
    logic [N-1:0] sv;
    int el;
    cyc++;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_press = '0; m_rel = '0;
      for (int c = 0; c < N; c++) anchor[c] = cyc;
    end else begin
      sv = m_s2;
      m_s2 = m_s1;
      m_s1 = btn_raw;
      m_press = '0;
      m_rel = '0;
      for (int c = 0; c < N; c++) begin
        if (sv[c] == m_lvl[c]) begin
          anchor[c] = cyc;
        end else if (cyc - anchor[c] == DB) begin
          m_lvl[c] = ~m_lvl[c];
          anchor[c] = cyc;
          if (m_lvl[c]) begin
            m_press[c] = 1'b1;
            press_t[c] = cyc;
          end else begin
            m_rel[c] = 1'b1;
          end
        end
        if (AR && m_lvl[c] && !m_press[c] && !m_rel[c]) begin
          el = cyc - press_t[c];
          if (el >= RD && (el - RD) % RP == 0) m_press[c] = 1'b1;
        end
      end
    end
  end

  bit run_cmp = 1'b0;
  always @(negedge clk) begin
    if (run_cmp) begin
      check("model_level", btn_level, m_lvl);
      check("model_press", btn_press, m_press);
      check("model_release", btn_release, m_rel);
      check("press_and_release", btn_press & btn_release, '0);
    end
  end

  initial begin
    int np, nr, pk, rk, first, act;
    bit bounce [6];
    bounce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    rst = 1'b1;
    btn_raw = '0;
    step(3);
    run_cmp = 1'b1;
    check("rst_level", btn_level, 3'b000);
    check("rst_press", btn_press, 3'b000);
    check("rst_release", btn_release, 3'b000);
    rst = 1'b0;

    // Clean press on ch0, level and pulse 6 edges later.
    btn_raw[0] = 1'b1;
    step(5);
    check("clean_pre_level", btn_level, 3'b000);
    step(1);
    check("clean_level", btn_level, 3'b001);
    check("clean_press", btn_press, 3'b001);
    step(1);
    check("clean_press_1cyc", btn_press, 3'b000);

    // Hold ch0: repeat pulses at +10, +13, ... relative to the press.
    np = 0; first = -1;
    for (int k = 2; k <= 30; k++) begin
      step(1);
      if (btn_press[0]) begin
        np++;
        if (first < 0) first = k;
      end
    end
    check("repeat_count", np, AR ? 7 : 0);
    check("repeat_first", first, AR ? 10 : -1);

    btn_raw[0] = 1'b0;
    nr = 0; np = 0;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      if (btn_release[0]) nr++;
      if (k == 6) check("release_edge", btn_release, 3'b001);
      if (k >= 7 && btn_press[0]) np++;
    end
    check("release_count", nr, 1);
    check("post_release_press", np, 0);

    // 3-cycle glitch on ch1 is rejected.
    act = 0;
    btn_raw[1] = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      step(1);
      if (k == 3) btn_raw[1] = 1'b0;
      act = act | int'(btn_level[1] | btn_press[1] | btn_release[1]);
    end
    check("glitch3_activity", act, 0);

    // 4-cycle pulse on ch1 is accepted.
    btn_raw[1] = 1'b1;
    np = 0; nr = 0; pk = -1; rk = -1;
    for (int k = 1; k <= 14; k++) begin
      step(1);
      if (k == 4) btn_raw[1] = 1'b0;
      if (btn_press[1]) begin np++; pk = k; end
      if (btn_release[1]) begin nr++; rk = k; end
    end
    check("pulse4_press_count", np, 1);
    check("pulse4_press_at", pk, 6);
    check("pulse4_release_count", nr, 1);
    check("pulse4_release_at", rk, 10);

    // Bouncing ch2 then steady high: one press 6 edges after last bounce.
    np = 0; pk = -1;
    for (int i = 0; i < 6; i++) begin
      btn_raw[2] = bounce[i];
      step(1);
      if (btn_press[2]) np++;
    end
    for (int k = 2; k <= 15; k++) begin
      step(1);
      if (btn_press[2]) begin
        np++;
        if (pk < 0) pk = k;
      end
    end
    check("bounce_press_count", np, 1);
    check("bounce_press_at", pk, 6);

    btn_raw[2] = 1'b0;
    step(12);

    // Simultaneous rise on ch0 and ch2.
    btn_raw[0] = 1'b1;
    btn_raw[2] = 1'b1;
    step(5);
    check("simul_pre_press", btn_press, 3'b000);
    step(1);
    check("simul_press", btn_press, 3'b101);
    check("simul_level", btn_level, 3'b101);

    // Reset mid-repeat with ch1 held.
    btn_raw = 3'b010;
    step(20);
    rst = 1'b1;
    step(1);
    check("midrst_level", btn_level, 3'b000);
    check("midrst_press", btn_press, 3'b000);
    check("midrst_release", btn_release, 3'b000);
    rst = 1'b0;
    step(5);
    check("postrst_pre_level", btn_level, 3'b000);
    step(1);
    check("postrst_press", btn_press, 3'b010);
    check("postrst_level", btn_level, 3'b010);

    // Random phase: fast toggling first, then long holds; rare resets.
    for (int k = 0; k < 4000; k++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, (k < 2000) ? 9 : 59) == 0) btn_raw[c] = ~btn_raw[c];
      end
      rst = ($urandom_range(0, 399) == 0);
      step(1);
    end
    rst = 1'b0;
    btn_raw = '0;
    step(20);
    run_cmp = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameter N_BTN, default 3, SHALL set the number of independent button channels (1..16).
REQ-002 Parameter DB_CYCLES, default 650000, SHALL set the debounce stability window in clk cycles (10 ms at 65 MHz, >=1).
REQ-003 Parameter REPEAT_DELAY, default 32500000, SHALL set the hold time in clk cycles before the first auto-repeat pulse (>=1).
REQ-004 Parameter REPEAT_PERIOD, default 6500000, SHALL set the spacing in clk cycles between later auto-repeat pulses (>=1).
REQ-005 clk  input  1  SHALL be the single system clock; all logic SHALL be on its rising edge.
REQ-006 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-007 btn_raw  input  N_BTN  SHALL carry the asynchronous, bouncing button pins, active-high.
REQ-008 btn_level  output  N_BTN  SHALL carry the debounced button state per channel.
REQ-009 btn_press  output  N_BTN  SHALL carry a 1-cycle pulse per press event, including auto-repeat events.
REQ-010 btn_release  output  N_BTN  SHALL carry a 1-cycle pulse per debounced release.

Function
REQ-011 Each channel SHALL pass btn_raw through a 2-flop synchroniser before any other logic.
REQ-012 Each channel SHALL hold a debounce counter of width $clog2(DB_CYCLES+1); the counter SHALL clear on any cycle where the synchronised value equals btn_level, and SHALL increment otherwise.
REQ-013 btn_level SHALL toggle on the cycle the counter would reach DB_CYCLES; the counter SHALL clear on that cycle.
REQ-014 A clean raw edge SHALL change btn_level exactly DB_CYCLES+2 rising edges after the first edge that samples the new raw value.
REQ-015 A raw excursion lasting fewer than DB_CYCLES synchronised cycles SHALL leave btn_level, btn_press and btn_release unchanged.
REQ-016 btn_press SHALL assert in the same cycle btn_level first reads 1; btn_release SHALL assert in the same cycle btn_level first reads 0; all outputs SHALL be registered.
REQ-017 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.
REQ-018 Per-channel repeat FSM states: IDLE, WAIT_DELAY, REPEATING. Rising btn_level SHALL move IDLE->WAIT_DELAY and load the repeat counter; falling btn_level SHALL move any state->IDLE in the same cycle it asserts btn_release.
REQ-019 Repeat counter width SHALL be $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1). It SHALL never wrap; it SHALL reload on every emitted pulse.
REQ-020 btn_press and btn_release SHALL never both assert on one channel in one cycle.

Reset
REQ-021 While rst is high, the synchronisers, counters, btn_level, btn_press and btn_release SHALL be 0 and every FSM SHALL be IDLE, within one clk edge.
REQ-022 Reset mid-debounce or mid-repeat SHALL discard all progress; a button held through reset SHALL produce btn_press DB_CYCLES+2 edges after rst deasserts.

Configuration
REQ-023 With BTN_AUTOREPEAT_EN defined: WAIT_DELAY SHALL emit a btn_press pulse REPEAT_DELAY cycles after the initial press, then enter REPEATING. REPEATING SHALL emit a pulse every REPEAT_PERIOD cycles while btn_level stays 1.
REQ-024 Without BTN_AUTOREPEAT_EN: the repeat FSM and its counters SHALL be absent, and each debounced press SHALL produce exactly one btn_press pulse.

Verification (bench overrides: N_BTN=3, DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-025 Clean raw[0] 0->1 held -> btn_level[0]=1 and a 1-cycle btn_press[0] appear 6 edges after the first sampling edge; ch1/ch2 stay 0.
REQ-026 raw[1] high for 3 cycles, then low -> no btn_level, btn_press or btn_release activity on ch1; a 4-cycle pulse SHALL be accepted.
REQ-027 Bouncy raw[2] (1,0,1,1,0,1 then steady 1) -> exactly one btn_press[2], 6 edges after the last bounce.
REQ-028 With BTN_AUTOREPEAT_EN, raw[0] held 30 cycles past the press -> btn_press[0] at press, +10, +13, +16, ... Release -> a single btn_release[0], and no further press pulses.
REQ-029 raw[0] and raw[2] rise in the same cycle -> btn_press[0] and btn_press[2] assert in the same cycle.
REQ-030 rst pulsed for 1 cycle while raw[1] is held and mid-repeat -> all outputs are 0 the next cycle, then btn_press[1] appears 6 edges after rst falls.
